// File: rtl/multi_ball_engine_pkg.sv
// Shared types and widths for the multi-ball sprite engine.
//   COORD_W  : screen coordinate width (unsigned pixel/line position)
//   VEL_W    : signed velocity / signed intermediate position width
//   IDX_W    : width of the ball index reported to the colour mux
//   fsm_state_t : update sequencer states
package multi_ball_engine_pkg;

  localparam int COORD_W = 11;
  localparam int VEL_W   = 12;
  localparam int IDX_W   = 4;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic {
    IDLE,
    UPDATE
  } fsm_state_t;

endpackage

// File: rtl/multi_ball_engine_if.sv
// Pixel-path bundle between the video timing generator / colour mux and
// the ball engine.
//   i_hcnt, i_vcnt      : raster position
//   i_width, i_height   : ball size shared by all balls
//   i_opposite          : request to reverse every ball at the next update
//   o_draw, o_ball_idx  : registered hit strobe and topmost ball index
//   o_busy              : update sequencer active
// master = timing/colour side, slave = engine.
interface multi_ball_engine_if;
  import multi_ball_engine_pkg::*;

  coord_t             i_hcnt;
  coord_t             i_vcnt;
  coord_t             i_width;
  coord_t             i_height;
  logic               i_opposite;
  logic               o_draw;
  logic [IDX_W-1:0]   o_ball_idx;
  logic               o_busy;

  modport master (
    output i_hcnt, i_vcnt, i_width, i_height, i_opposite,
    input  o_draw, o_ball_idx, o_busy
  );

  modport slave (
    input  i_hcnt, i_vcnt, i_width, i_height, i_opposite,
    output o_draw, o_ball_idx, o_busy
  );

endinterface

// File: rtl/multi_ball_engine_ball_axis_step.sv
// Combinational single-axis motion step for one ball.
//   pos, vel   : current position and signed velocity
//   size       : ball extent on this axis
//   opposite   : reverse the velocity before moving
//   pos_next, vel_next : updated position and velocity
// RES is the active extent of the axis (width or height of the screen).
module ball_axis_step
  import multi_ball_engine_pkg::*;
#(
  parameter int RES = 640
) (
  input  coord_t pos,
  input  vel_t   vel,
  input  coord_t size,
  input  logic   opposite,
  output coord_t pos_next,
  output vel_t   vel_next
);

  vel_t vel_eff;
  vel_t nx;
  vel_t lim;
  logic pinned;

  always_comb begin
    vel_eff  = opposite ? -vel : vel;
    nx       = $signed({1'b0, pos}) + vel_eff;
    lim      = VEL_W'(RES) - $signed({1'b0, size});
    // A ball as large as the screen has no room to move.
    pinned   = (size >= COORD_W'(RES));
    pos_next = nx[COORD_W-1:0];
    vel_next = vel_eff;
    if (pinned) begin
      pos_next = '0;
    end else if ((nx >= lim) && !vel_eff[VEL_W-1] && (vel_eff != '0)) begin
      // Far edge: clamp onto the edge and bounce.
      pos_next = lim[COORD_W-1:0];
      vel_next = -vel_eff;
    end else if (nx[VEL_W-1] && vel_eff[VEL_W-1]) begin
      // Near edge: clamp to zero and bounce.
      pos_next = '0;
      vel_next = -vel_eff;
    end
  end

endmodule

// File: rtl/multi_ball_engine.sv
// NUM_BALLS independent bouncing balls. Once per frame (hcnt==vcnt==0) a
// sequencer steps each ball in turn through a shared x/y step unit; every
// pixel is tested against all balls and the lowest-index hit is reported
// one clock later.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : slave side of multi_ball_engine_if (counters, size,
//              opposite request in; draw, ball index, busy out)
module multi_ball_engine
  import multi_ball_engine_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int X_RES     = 640,
  parameter int Y_RES     = 480,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int SPACING_X = 64,
  parameter int SPACING_Y = 32,
  parameter int DELTA_X   = 1,
  parameter int DELTA_Y   = 1
) (
  input logic                clk,
  input logic                rst,
  multi_ball_engine_if.slave bus
);

  fsm_state_t       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             busy_reg;
  logic             pending_reg;
  logic             apply_reg;
  logic             draw_reg;
  logic [IDX_W-1:0] ball_idx_reg;

  coord_t x_pos [NUM_BALLS];
  coord_t y_pos [NUM_BALLS];
  vel_t   x_vel [NUM_BALLS];
  vel_t   y_vel [NUM_BALLS];
  logic [NUM_BALLS-1:0] hit;

  coord_t cur_x, cur_y, x_step, y_step;
  vel_t   cur_dx, cur_dy, dx_step, dy_step;
  logic   hit_any;
  logic [IDX_W-1:0] hit_idx;

  logic tick;
  assign tick = (bus.i_hcnt == '0) && (bus.i_vcnt == '0);

  // Sequencer. apply_reg holds this frame's reversal decision so that a
  // request arriving mid-update waits in pending_reg for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      busy_reg    <= 1'b0;
      pending_reg <= 1'b0;
      apply_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_reg   <= UPDATE;
            idx_reg     <= '0;
            busy_reg    <= 1'b1;
            apply_reg   <= pending_reg | bus.i_opposite;
            pending_reg <= 1'b0;
          end else begin
            pending_reg <= pending_reg | bus.i_opposite;
          end
        end
        UPDATE: begin
          pending_reg <= pending_reg | bus.i_opposite;
          if (idx_reg == IDX_W'(NUM_BALLS - 1)) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            apply_reg <= 1'b0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Select the ball being updated for the shared step units.
  always_comb begin
    cur_x  = '0;
    cur_y  = '0;
    cur_dx = '0;
    cur_dy = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        cur_x  = x_pos[i];
        cur_y  = y_pos[i];
        cur_dx = x_vel[i];
        cur_dy = y_vel[i];
      end
    end
  end

  ball_axis_step #(.RES(X_RES)) u_step_x (
    .pos      (cur_x),
    .vel      (cur_dx),
    .size     (bus.i_width),
    .opposite (apply_reg),
    .pos_next (x_step),
    .vel_next (dx_step)
  );

  ball_axis_step #(.RES(Y_RES)) u_step_y (
    .pos      (cur_y),
    .vel      (cur_dy),
    .size     (bus.i_height),
    .opposite (apply_reg),
    .pos_next (y_step),
    .vel_next (dy_step)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
      localparam coord_t RST_X  = COORD_W'(START_X + gi * SPACING_X);
      localparam coord_t RST_Y  = COORD_W'(START_Y + gi * SPACING_Y);
      localparam vel_t   RST_DX = VEL_W'(DELTA_X + gi);
      localparam vel_t   RST_DY = VEL_W'(DELTA_Y + gi);

      coord_t x_reg, y_reg;
      vel_t   dx_reg, dy_reg;
      coord_t rel_h, rel_v;
      logic   sel;

      assign sel = (state_reg == UPDATE) && (idx_reg == IDX_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_reg  <= RST_X;
          y_reg  <= RST_Y;
          dx_reg <= RST_DX;
          dy_reg <= RST_DY;
        end else if (sel) begin
          x_reg  <= x_step;
          y_reg  <= y_step;
          dx_reg <= dx_step;
          dy_reg <= dy_step;
        end
      end

      assign x_pos[gi] = x_reg;
      assign y_pos[gi] = y_reg;
      assign x_vel[gi] = dx_reg;
      assign y_vel[gi] = dy_reg;

      // Modular distance: pixels left of/above the ball wrap to large values,
      // so one unsigned compare covers both bounds; size 0 never hits.
      assign rel_h   = bus.i_hcnt - x_reg;
      assign rel_v   = bus.i_vcnt - y_reg;
      assign hit[gi] = (rel_h < bus.i_width) && (rel_v < bus.i_height);
    end
  endgenerate

  // Priority encoder: scanning downward leaves the lowest hit index.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_reg     <= 1'b0;
      ball_idx_reg <= '0;
    end else begin
      draw_reg     <= hit_any;
      ball_idx_reg <= hit_idx;
    end
  end

  assign bus.o_draw     = draw_reg;
  assign bus.o_ball_idx = ball_idx_reg;
  assign bus.o_busy     = busy_reg;

endmodule
